hamming74_decoder: RTL and testbench

//  Receive-side partner of the Hamming(7,4) encoder. Takes 7-bit codewords over a valid/ready

---
 rtl/hamming74_decoder.sv | 96 +++++++++
 tb/tb_hamming74_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_decoder.sv
// Hamming(7,4) stream decoder: two-stage valid/ready pipeline that corrects single-bit errors,
// reports the syndrome and keeps saturating delivered/corrected word counters.
module hamming74_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       s1_valid;
  logic [6:0] s1_code;
  logic [2:0] s1_syn;
  logic [2:0] in_syn;
  logic [6:0] fixed_code;
  logic       ld1;
  logic       ld2;
  logic       out_fire;

  // Syndrome {s4,s2,s1} is the 1-based position of a single flipped bit.
  assign in_syn = {code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6],
                   code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6],
                   code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6]};

  assign ld2      = !out_valid || out_ready;
  assign ld1      = !s1_valid || ld2;
  assign in_ready = ld1;
  assign out_fire = out_valid && out_ready;

  // NOTE: every variable driven here gets a default before the loop, so no latch is inferred.
  always_comb begin
    fixed_code = s1_code;
    for (int i = 0; i < 7; i++) begin
      fixed_code[i] = s1_code[i] ^ (s1_syn == 3'(i + 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the pipeline registers are few,
  // so the data path is reset along with the valid bits to keep outputs defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (ld1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= code_in;
        s1_syn  <= in_syn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
    end else if (ld2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out      <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
        out_syndrome  <= s1_syn;
        out_corrected <= |s1_syn;
      end
    end
  end

  // Clear takes priority over a same-cycle delivery; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      corr_cnt <= '0;
    end else if (cnt_clr) begin
      word_cnt <= '0;
      corr_cnt <= '0;
    end else if (out_fire) begin
      if (word_cnt != CNT_MAX) word_cnt <= word_cnt + CNT_W'(1);
      if (out_corrected && (corr_cnt != CNT_MAX)) corr_cnt <= corr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming74_decoder.sv
// Self-checking bench for hamming74_decoder: scoreboard of expected words, directed and
// exhaustive error patterns, backpressure, counter saturation/clear and mid-stream reset.
module tb_hamming74_decoder;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [6:0] code_in = '0;

  logic        in_ready, out_valid, out_corrected;
  logic [3:0]  data_out;
  logic [2:0]  out_syndrome;
  logic [15:0] word_cnt, corr_cnt;

  logic        s_in_ready, s_out_valid, s_out_corrected;
  logic [3:0]  s_data_out;
  logic [2:0]  s_out_syndrome;
  logic [1:0]  s_word_cnt, s_corr_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hamming74_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected), .cnt_clr(cnt_clr),
    .word_cnt(word_cnt), .corr_cnt(corr_cnt)
  );

  hamming74_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .code_in(code_in),
    .out_valid(s_out_valid), .out_ready(out_ready), .data_out(s_data_out),
    .out_syndrome(s_out_syndrome), .out_corrected(s_out_corrected), .cnt_clr(cnt_clr),
    .word_cnt(s_word_cnt), .corr_cnt(s_corr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference encoder: positions 1..7 = p1,p2,d0,p4,d1,d2,d3.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  // flip = 0 means no error, otherwise the 1-based position to corrupt.
  function automatic logic [6:0] make_code(input logic [3:0] d, input int flip);
    logic [6:0] c;
    c = encode(d);
    if (flip != 0) c[flip-1] = ~c[flip-1];
    return c;
  endfunction

  function automatic exp_t make_exp(input logic [3:0] d, input int flip);
    exp_t e;
    e.data = d;
    e.syn  = 3'(flip);
    e.corr = (flip != 0);
    return e;
  endfunction

  // One clock: drive at the falling edge, observe handshakes, then cross the rising edge.
  task automatic step(input logic v, input logic [6:0] code, input exp_t e,
                      input logic ordy, input logic clr, output logic acc);
    exp_t got;
    in_valid  = v;
    code_in   = code;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        got = sb.pop_front();
        check("data_out", {28'd0, data_out}, {28'd0, got.data});
        check("syndrome", {29'd0, out_syndrome}, {29'd0, got.syn});
        check("corrected", {31'd0, out_corrected}, {31'd0, got.corr});
      end
    end
    acc = v && in_ready;
    if (acc) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic acc;
    step(1'b0, 7'd0, '0, ordy, clr, acc);
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      idle(1'b1, 1'b0);
      budget--;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic send(input logic [6:0] code, input exp_t e, input logic ordy);
    logic acc;
    step(1'b1, code, e, ordy, 1'b0, acc);
    check("send_accept", {31'd0, acc}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [3:0] held;
    int budget;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data_out", {28'd0, data_out}, 32'd0);
    check("rst_syndrome", {29'd0, out_syndrome}, 32'd0);
    check("rst_corrected", {31'd0, out_corrected}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("rst_corr_cnt", {16'd0, corr_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Clean word with two-cycle latency.
    send(7'b0101101, '{4'b0101, 3'd0, 1'b0}, 1'b1);
    check("lat_n1", {31'd0, out_valid}, 32'd0);
    idle(1'b1, 1'b0);
    check("lat_n2", {31'd0, out_valid}, 32'd1);
    drain();

    // Data-bit error at position 5.
    send(7'b0111101, '{4'b0101, 3'd5, 1'b1}, 1'b1);
    drain();
    check("corr_cnt_after_data_err", {16'd0, corr_cnt}, 32'd1);

    // Parity-bit error at position 1.
    send(7'b1111110, '{4'b1111, 3'd1, 1'b1}, 1'b1);
    drain();
    check("word_cnt_directed", {16'd0, word_cnt}, 32'd3);
    check("corr_cnt_directed", {16'd0, corr_cnt}, 32'd2);

    // Exhaustive stream with random downstream stalls.
    idle(1'b1, 1'b1);
    for (int d = 0; d < 16; d++) begin
      for (int f = 0; f < 8; f++) begin
        budget = 60;
        acc = 1'b0;
        while (!acc && budget > 0) begin
          step(1'b1, make_code(4'(d), f), make_exp(4'(d), f), 1'($urandom_range(0, 1)), 1'b0, acc);
          budget--;
        end
        if (!acc) check("exh_accept_timeout", 32'd0, 32'd1);
      end
    end
    drain();
    check("exh_word_cnt", {16'd0, word_cnt}, 32'd128);
    check("exh_corr_cnt", {16'd0, corr_cnt}, 32'd112);

    // Backpressure: two words fill both stages, input stalls, outputs hold.
    send(make_code(4'hA, 0), make_exp(4'hA, 0), 1'b0);
    send(make_code(4'h3, 6), make_exp(4'h3, 6), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, make_code(4'h7, 0), make_exp(4'h7, 0), 1'b0, 1'b0, acc);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_no_accept", {31'd0, acc}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {28'd0, data_out}, 32'hA);
    end
    idle(1'b1, 1'b0);
    check("bp_consecutive", {31'd0, out_valid}, 32'd1);
    check("bp_second_word", {28'd0, data_out}, 32'h3);
    drain();

    // Saturation with the 2-bit counter instance, then clear racing a delivery.
    idle(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) send(make_code(4'(i), i), make_exp(4'(i), i), 1'b1);
    drain();
    check("sat_word_cnt", {30'd0, s_word_cnt}, 32'd3);
    check("sat_corr_cnt", {30'd0, s_corr_cnt}, 32'd3);
    check("wide_word_cnt", {16'd0, word_cnt}, 32'd5);
    send(make_code(4'hC, 2), make_exp(4'hC, 2), 1'b0);
    idle(1'b0, 1'b0);
    check("clr_pending", {31'd0, out_valid}, 32'd1);
    idle(1'b1, 1'b1);
    check("clr_sb_empty", sb.size(), 32'd0);
    check("clr_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("clr_sat_word_cnt", {30'd0, s_word_cnt}, 32'd0);
    check("clr_sat_corr_cnt", {30'd0, s_corr_cnt}, 32'd0);

    // Reset with two words in flight discards them.
    send(make_code(4'h9, 0), make_exp(4'h9, 0), 1'b0);
    send(make_code(4'h6, 3), make_exp(4'h6, 3), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sat_out_valid", {31'd0, s_out_valid}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_data_out", {28'd0, data_out}, 32'd0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    check("midrst_word_cnt", {16'd0, word_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
